// File: rtl/rv_decode_pkg.sv
// Shared constants and decoded-entry layout for the RV32I decode stage.
package rv_decode_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FUN3_W  = 3;
  localparam int unsigned FUN7_W  = 7;
  localparam int unsigned FMT_W   = 6;

  localparam logic [OPC_W-1:0] OPC_LUI     = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL     = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR    = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD    = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE   = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP      = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM  = 7'b1110011;

  // Bit positions inside the one-hot format vector {J,U,B,S,I,R}
  localparam int unsigned FMT_R = 0;
  localparam int unsigned FMT_I = 1;
  localparam int unsigned FMT_S = 2;
  localparam int unsigned FMT_B = 3;
  localparam int unsigned FMT_U = 4;
  localparam int unsigned FMT_J = 5;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [FUN3_W-1:0] fun3;
    logic [FUN7_W-1:0] fun7;
    logic [FMT_W-1:0]  fmt;
    logic              illegal;
    logic              rd_we;
    logic              rs1_used;
    logic              rs2_used;
  } dec_fields_t;

endpackage

// File: rtl/rv_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface rv_decode_stage_if
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [INSTR_W-1:0]  in_instr;
  logic [XLEN-1:0]     in_pc;

  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_pc;
  logic [OPC_W-1:0]    out_opcode;
  logic [REG_W-1:0]    out_rd;
  logic [REG_W-1:0]    out_rs1;
  logic [REG_W-1:0]    out_rs2;
  logic [FUN3_W-1:0]   out_fun3;
  logic [FUN7_W-1:0]   out_fun7;
  logic [XLEN-1:0]     out_imm;
  logic [FMT_W-1:0]    out_fmt;
  logic                out_illegal;
  logic                out_rd_we;
  logic                out_rs1_used;
  logic                out_rs2_used;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_fun3, out_fun7, out_imm, out_fmt, out_illegal, out_rd_we,
           out_rs1_used, out_rs2_used
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_fun3, out_fun7, out_imm, out_fmt, out_illegal, out_rd_we,
           out_rs1_used, out_rs2_used
  );
endinterface

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I decoder: fields, format, legality, immediate, register use.
// RV_DECODE_RVE_EN restricts used register indices to x0..x15.
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter bit          SYSTEM_LEGAL = 1'b1
) (
  input  logic [INSTR_W-1:0] instr,
  output dec_fields_t        fields_c,
  output logic [XLEN-1:0]    imm_c
);

  logic [OPC_W-1:0]  opc;
  logic [FUN3_W-1:0] f3;
  logic [FUN7_W-1:0] f7;
  logic [FMT_W-1:0]  fmt;
  logic              legal;
  logic [31:0]       imm_i, imm_s, imm_b, imm_u, imm_j, imm32;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Format and legality per major opcode
  always_comb begin
    fmt   = '0;
    legal = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin fmt[FMT_U] = 1'b1; legal = 1'b1; end
      OPC_JAL:     begin fmt[FMT_J] = 1'b1; legal = 1'b1; end
      OPC_JALR:    begin fmt[FMT_I] = 1'b1; legal = (f3 == 3'b000); end
      OPC_BRANCH:  begin fmt[FMT_B] = 1'b1; legal = (f3 != 3'b010) && (f3 != 3'b011); end
      OPC_LOAD:    begin fmt[FMT_I] = 1'b1; legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111); end
      OPC_STORE:   begin fmt[FMT_S] = 1'b1; legal = (f3 <= 3'b010); end
      OPC_OPIMM: begin
        fmt[FMT_I] = 1'b1;
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
      end
      OPC_OP: begin
        fmt[FMT_R] = 1'b1;
        legal = (f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_MISCMEM: begin fmt[FMT_I] = 1'b1; legal = (f3 == 3'b000); end
      OPC_SYSTEM:  begin fmt[FMT_I] = 1'b1; legal = SYSTEM_LEGAL; end
      default: ;
    endcase
    if (instr[1:0] != 2'b11) legal = 1'b0;
    if (!legal) fmt = '0;
  end

  // Immediate selection; R-format and illegal leave it zero
  always_comb begin
    imm32 = '0;
    if (fmt[FMT_I])      imm32 = imm_i;
    else if (fmt[FMT_S]) imm32 = imm_s;
    else if (fmt[FMT_B]) imm32 = imm_b;
    else if (fmt[FMT_U]) imm32 = imm_u;
    else if (fmt[FMT_J]) imm32 = imm_j;
  end

  assign imm_c = XLEN'($signed(imm32));

  // Field packing and register-use derivation
  always_comb begin
    fields_c          = '0;
    fields_c.opcode   = opc;
    fields_c.rd       = instr[11:7];
    fields_c.rs1      = instr[19:15];
    fields_c.rs2      = instr[24:20];
    fields_c.fun3     = f3;
    fields_c.fun7     = f7;
    fields_c.fmt      = fmt;
    fields_c.illegal  = !legal;
    fields_c.rd_we    = (fmt[FMT_R] | fmt[FMT_I] | fmt[FMT_U] | fmt[FMT_J]) &&
                        (instr[11:7] != 5'd0) && (opc != OPC_MISCMEM);
    fields_c.rs1_used = (fmt[FMT_R] | fmt[FMT_I] | fmt[FMT_S] | fmt[FMT_B]) &&
                        (opc != OPC_MISCMEM) && !((opc == OPC_SYSTEM) && (f3 == 3'b000));
    fields_c.rs2_used = fmt[FMT_R] | fmt[FMT_S] | fmt[FMT_B];
`ifdef RV_DECODE_RVE_EN
    if ((fields_c.rd_we && fields_c.rd[4]) || (fields_c.rs1_used && fields_c.rs1[4]) ||
        (fields_c.rs2_used && fields_c.rs2[4])) begin
      fields_c.illegal  = 1'b1;
      fields_c.rd_we    = 1'b0;
      fields_c.rs1_used = 1'b0;
      fields_c.rs2_used = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage: main + skid entry, valid/ready on both sides, synchronous flush.
// RV_DECODE_RVE_EN (in rv_decode_comb) selects the RV32E register-index check.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter bit          SYSTEM_LEGAL = 1'b1
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  rv_decode_stage_if.slave  bus
);

  dec_fields_t       dec_f;
  logic [XLEN-1:0]   dec_imm;

  dec_fields_t       main_f, skid_f;
  logic [XLEN-1:0]   main_imm, skid_imm;
  logic [XLEN-1:0]   main_pc, skid_pc;
  logic              main_v, skid_v;
  logic              accept, fire;

  rv_decode_comb #(.XLEN(XLEN), .SYSTEM_LEGAL(SYSTEM_LEGAL)) u_comb (
    .instr    (bus.in_instr),
    .fields_c (dec_f),
    .imm_c    (dec_imm)
  );

  assign accept = bus.in_valid && !skid_v;
  assign fire   = main_v && bus.out_ready;

  // Skid can only fill while main is stalled, so order is main then skid
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
      main_f   <= '0;
      main_imm <= '0;
      main_pc  <= '0;
      skid_f   <= '0;
      skid_imm <= '0;
      skid_pc  <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (fire) begin
      if (skid_v) begin
        main_f   <= skid_f;
        main_imm <= skid_imm;
        main_pc  <= skid_pc;
        skid_v   <= 1'b0;
      end else if (accept) begin
        main_f   <= dec_f;
        main_imm <= dec_imm;
        main_pc  <= bus.in_pc;
      end else begin
        main_v <= 1'b0;
      end
    end else if (accept) begin
      if (main_v) begin
        skid_f   <= dec_f;
        skid_imm <= dec_imm;
        skid_pc  <= bus.in_pc;
        skid_v   <= 1'b1;
      end else begin
        main_f   <= dec_f;
        main_imm <= dec_imm;
        main_pc  <= bus.in_pc;
        main_v   <= 1'b1;
      end
    end
  end

  assign bus.in_ready     = !skid_v;
  assign bus.out_valid    = main_v;
  assign bus.out_pc       = main_pc;
  assign bus.out_opcode   = main_f.opcode;
  assign bus.out_rd       = main_f.rd;
  assign bus.out_rs1      = main_f.rs1;
  assign bus.out_rs2      = main_f.rs2;
  assign bus.out_fun3     = main_f.fun3;
  assign bus.out_fun7     = main_f.fun7;
  assign bus.out_imm      = main_imm;
  assign bus.out_fmt      = main_f.fmt;
  assign bus.out_illegal  = main_f.illegal;
  assign bus.out_rd_we    = main_f.rd_we;
  assign bus.out_rs1_used = main_f.rs1_used;
  assign bus.out_rs2_used = main_f.rs2_used;

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
Registered RV32I decode pipeline stage between fetch and execute. It extracts all instruction fields and selects the single format-correct immediate, sign-extended to XLEN. It also classifies the format one-hot, flags illegal encodings and derives register-use bits. Valid/ready handshake on both sides, a 2-entry skid buffer for full throughput under backpressure, and a synchronous flush for branch redirect.

Parameters:
XLEN, 32, datapath/PC width; 32 or 64; immediates sign-extended to XLEN
SYSTEM_LEGAL, 1, 1: SYSTEM opcode (1110011) decodes legal; 0: flagged illegal

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept
in_instr  in  32  raw instruction word
in_pc  in  XLEN  PC of in_instr
out_valid  out  1  decoded entry valid
out_ready  in  1  downstream accepts
out_pc  out  XLEN  carried PC
out_opcode  out  7  instr[6:0]
out_rd / out_rs1 / out_rs2  out  5 each  instr[11:7] / [19:15] / [24:20]
out_fun3  out  3  instr[14:12]
out_fun7  out  7  instr[31:25]
out_imm  out  XLEN  selected immediate; 0 for R-format and illegal
out_fmt  out  6  one-hot {J,U,B,S,I,R}; 0 when illegal
out_illegal  out  1  illegal encoding
out_rd_we  out  1  writes rd (fmt R/I/U/J, rd!=0, not STORE/BRANCH/FENCE)
out_rs1_used / out_rs2_used  out  1  rs1 read (R/I/S/B, excluding FENCE/ECALL/EBREAK) / rs2 read (R/S/B)

Behaviour:
- Reset (rst=1 at edge): both entries invalid, out_valid=0, in_ready=1. All data outputs 0. rst overrides flush and handshakes.
- Decode is combinational on in_instr and is captured only on accept (in_valid && in_ready). Latency is 1 cycle: accepted at edge N, visible at out_* after edge N.
- Storage is a main register (drives out_*) plus a skid register. in_ready = !skid_valid, registered, with no combinational path from out_ready.
- Each edge:
  - Output fire: out_valid && out_ready. On fire, the skid entry (if valid) moves to main, else main takes the new accept, else main empties.
  - Accept while main is held and not firing: the entry goes to skid.
  - Simultaneous fire and accept with skid empty: the new entry goes directly to main.
- Order is strictly preserved. Sustained 1/cycle with out_ready=1.
- flush=1: both entries invalid next cycle. Any same-cycle accept is dropped. in_ready=1 next cycle.
- Immediates:
  - I = sext(i[31:20])
  - S = sext({i[31:25],i[11:7]})
  - B = sext({i[31],i[7],i[30:25],i[11:8],0})
  - U = sext({i[31:12],12'b0})
  - J = sext({i[31],i[19:12],i[20],i[30:21],0})
- Legal encodings (anything else gives illegal=1, fmt=0, imm=0, rd_we=0, uses=0):
  - i[1:0] must be 11.
  - LUI 0110111 U; AUIPC 0010111 U; JAL 1101111 J.
  - JALR 1100111 I, fun3=000.
  - BRANCH 1100011 B, fun3 not 010/011.
  - LOAD 0000011 I, fun3 in {000,001,010,100,101}.
  - STORE 0100011 S, fun3 <= 010.
  - OP-IMM 0010011 I; fun3=001 needs fun7=0; fun3=101 needs fun7 in {0000000,0100000}.
  - OP 0110011 R; fun7=0000000, or fun7=0100000 only with fun3 000/101.
  - MISC-MEM 0001111 I, fun3=000.
  - SYSTEM 1110011 I, gated by SYSTEM_LEGAL.
- Illegal instructions still flow through the pipe with their PC. Execute raises the trap.

Optional Feature:
Macro RV_DECODE_RVE_EN.
- Defined: RV32E register file. Any used register index (rd when rd_we, rs1 when rs1_used, rs2 when rs2_used) with bit 4 set forces out_illegal=1, and clears rd_we and the use bits.
- Undefined: all 32 indices legal; no extra logic.

Decomposition:
- Package rv_decode_pkg holds:
  - opcode localparams: OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_MISCMEM, OPC_SYSTEM;
  - format one-hot bit indices FMT_R..FMT_J;
  - decoded-entry field widths.
- Sub-module rv_decode_comb: the pure combinational decoder (fields, imm, fmt, illegal, uses). The top holds only the skid/handshake logic.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, fmt=I, rd=1, imm=0xFFFFFFFF, rd_we=1, rs1_used=1, rs2_used=0.
- 0x00112623 (sw x1,12(x2)) -> fmt=S, imm=0x0000000C, rs1=2, rs2=1, rd_we=0. 0xFE000EE3 (beq x0,x0,-4) -> fmt=B, imm=0xFFFFFFFC.
- 0x001000EF (jal x1,2048) -> fmt=J, imm=0x00000800, rd_we=1. 0x12345037 (lui x0) -> fmt=U, imm=0x12345000, rd_we=0 (rd=0).
- Backpressure: out_ready=0, present A,B,C back-to-back -> A,B accepted, in_ready=0 from cycle 2. Raise out_ready -> A,B,C emerge in order with no loss or duplicate.
- 0x00000000 and 0x40001033 (fun7=0100000, fun3=001) -> illegal=1, fmt=0, imm=0. Also with SYSTEM_LEGAL=0: 0x00000073 -> illegal=1.
- Two entries held, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed entries never appear. Same sequence with rst instead gives the same result. With RV_DECODE_RVE_EN, 0x01000093 (addi x1,x0,16) is legal and 0x00000893 (addi x17) is illegal.
